// File: rtl/muldiv_ctrl.sv
// Iterative radix-2 multiply / restoring divide sequencer for the EXE stage.
// Optional macro MULDIV_FAST_MUL_EN: multiplies complete in one cycle via a combinational product.
module muldiv_ctrl #(
    parameter int DATA_WIDTH = 32,
    parameter int CNT_WIDTH  = 6
) (
    input  logic                  clk_in,
    input  logic                  reset_n_in,
    input  logic                  op_valid_in,
    input  logic [2:0]            op_in,
    input  logic [DATA_WIDTH-1:0] src_a_in,
    input  logic [DATA_WIDTH-1:0] src_b_in,
    input  logic                  flush_in,
    output logic                  stallreq_out,
    output logic [DATA_WIDTH-1:0] result_out,
    output logic                  result_valid_out,
    output logic                  busy_out
);
    localparam int W = DATA_WIDTH;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_CALC = 2'd1,
        S_DONE = 2'd2
    } state_t;

    localparam logic [2:0] OP_MUL    = 3'd0;
    localparam logic [2:0] OP_MULH   = 3'd1;
    localparam logic [2:0] OP_MULHSU = 3'd2;
    localparam logic [2:0] OP_DIV    = 3'd4;
    localparam logic [2:0] OP_REM    = 3'd6;

    state_t               state_q, state_d;
    logic [2:0]           op_q, op_d;
    logic [CNT_WIDTH-1:0] cnt_q, cnt_d;
    // Multiply: {partial product, multiplier}; divide: {remainder, quotient}.
    logic [2*W-1:0]       acc_q, acc_d;
    logic [W-1:0]         opb_q, opb_d;
    logic                 neg_q, neg_d;
    logic                 negrem_q, negrem_d;
    logic                 byp_q, byp_d;

    logic         a_signed, b_signed, a_neg, b_neg;
    logic [W-1:0] a_abs, b_abs;
    logic         div0, ovf;

    always_comb begin
        a_signed = (op_in == OP_MULH) || (op_in == OP_MULHSU) || (op_in == OP_DIV) || (op_in == OP_REM);
        b_signed = (op_in == OP_MULH) || (op_in == OP_DIV) || (op_in == OP_REM);
        a_neg    = a_signed & src_a_in[W-1];
        b_neg    = b_signed & src_b_in[W-1];
        a_abs    = a_neg ? -src_a_in : src_a_in;
        b_abs    = b_neg ? -src_b_in : src_b_in;
        div0     = op_in[2] && (src_b_in == '0);
        ovf      = ((op_in == OP_DIV) || (op_in == OP_REM)) &&
                   (src_a_in == {1'b1, {(W-1){1'b0}}}) && (src_b_in == {W{1'b1}});
    end

    logic [W:0]     mul_sum;
    logic [2*W-1:0] mul_step;
    logic [W:0]     div_shift, div_diff;
    logic [2*W-1:0] div_step;

    always_comb begin
        mul_sum   = {1'b0, acc_q[2*W-1:W]} + (acc_q[0] ? {1'b0, opb_q} : {(W+1){1'b0}});
        mul_step  = {mul_sum, acc_q[W-1:1]};
        div_shift = acc_q[2*W-1:W-1];
        div_diff  = div_shift - {1'b0, opb_q};
        if (!div_diff[W]) begin
            div_step = {div_diff[W-1:0], acc_q[W-2:0], 1'b1};
        end else begin
            div_step = {div_shift[W-1:0], acc_q[W-2:0], 1'b0};
        end
    end

`ifdef MULDIV_FAST_MUL_EN
    logic [2*W-1:0] prod_fast;
    assign prod_fast = {{W{1'b0}}, a_abs} * {{W{1'b0}}, b_abs};
`endif

    always_comb begin
        state_d  = state_q;
        op_d     = op_q;
        cnt_d    = cnt_q;
        acc_d    = acc_q;
        opb_d    = opb_q;
        neg_d    = neg_q;
        negrem_d = negrem_q;
        byp_d    = byp_q;
        case (state_q)
            S_IDLE: begin
                if (op_valid_in && !flush_in) begin
                    op_d     = op_in;
                    neg_d    = a_neg ^ b_neg;
                    negrem_d = a_neg;
                    opb_d    = b_abs;
                    byp_d    = 1'b0;
                    if (div0) begin
                        byp_d   = 1'b1;
                        acc_d   = {{W{1'b0}}, (op_in[1] ? src_a_in : {W{1'b1}})};
                        state_d = S_DONE;
                    end else if (ovf) begin
                        byp_d   = 1'b1;
                        acc_d   = {{W{1'b0}}, (op_in[1] ? {W{1'b0}} : src_a_in)};
                        state_d = S_DONE;
`ifdef MULDIV_FAST_MUL_EN
                    end else if (!op_in[2]) begin
                        acc_d   = prod_fast;
                        state_d = S_DONE;
`endif
                    end else begin
                        acc_d   = {{W{1'b0}}, a_abs};
                        cnt_d   = CNT_WIDTH'(W);
                        state_d = S_CALC;
                    end
                end
            end
            S_CALC: begin
                acc_d = op_q[2] ? div_step : mul_step;
                cnt_d = cnt_q - CNT_WIDTH'(1);
                if (cnt_q == CNT_WIDTH'(1)) begin
                    state_d = S_DONE;
                end
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
        if (flush_in) begin
            state_d = S_IDLE;
        end
    end

    always_ff @(posedge clk_in or negedge reset_n_in) begin
        if (!reset_n_in) begin
            state_q  <= S_IDLE;
            op_q     <= '0;
            cnt_q    <= '0;
            acc_q    <= '0;
            opb_q    <= '0;
            neg_q    <= 1'b0;
            negrem_q <= 1'b0;
            byp_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            op_q     <= op_d;
            cnt_q    <= cnt_d;
            acc_q    <= acc_d;
            opb_q    <= opb_d;
            neg_q    <= neg_d;
            negrem_q <= negrem_d;
            byp_q    <= byp_d;
        end
    end

    // Sign correction is applied only on the way out, in the DONE cycle.
    logic [2*W-1:0] prod_fix;
    logic [W-1:0]   quo_fix, rem_fix, res_sel;

    always_comb begin
        prod_fix = neg_q ? -acc_q : acc_q;
        quo_fix  = neg_q ? -acc_q[W-1:0] : acc_q[W-1:0];
        rem_fix  = negrem_q ? -acc_q[2*W-1:W] : acc_q[2*W-1:W];
        res_sel  = '0;
        if (byp_q) begin
            res_sel = acc_q[W-1:0];
        end else begin
            case (op_q)
                3'd0:                res_sel = prod_fix[W-1:0];
                3'd1, 3'd2, 3'd3:    res_sel = prod_fix[2*W-1:W];
                3'd4, 3'd5:          res_sel = quo_fix;
                default:             res_sel = rem_fix;
            endcase
        end
    end

    assign busy_out         = (state_q != S_IDLE);
    assign result_valid_out = (state_q == S_DONE) && !flush_in;
    assign result_out       = (state_q == S_DONE) ? res_sel : '0;
    assign stallreq_out     = op_valid_in && !flush_in && (state_q != S_DONE);

endmodule

// File: tb/tb_muldiv_ctrl.sv
// Directed bench for muldiv_ctrl: arithmetic reference model checked every cycle plus literal expectations.
module tb_muldiv_ctrl;
    localparam int W = 32;
`ifdef MULDIV_FAST_MUL_EN
    localparam int MUL_STALL = 1;
`else
    localparam int MUL_STALL = 33;
`endif

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          op_valid = 1'b0;
    logic [2:0]    op_sel = 3'd0;
    logic [W-1:0]  src_a = '0;
    logic [W-1:0]  src_b = '0;
    logic          flush = 1'b0;
    logic          stallreq;
    logic [W-1:0]  result;
    logic          res_valid;
    logic          busy;

    int total = 0;
    int bad   = 0;

    muldiv_ctrl #(.DATA_WIDTH(W), .CNT_WIDTH(6)) dut (
        .clk_in           (clk),
        .reset_n_in       (rst_n),
        .op_valid_in      (op_valid),
        .op_in            (op_sel),
        .src_a_in         (src_a),
        .src_b_in         (src_b),
        .flush_in         (flush),
        .stallreq_out     (stallreq),
        .result_out       (result),
        .result_valid_out (res_valid),
        .busy_out         (busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h @%0t", name, got, exp, $time);
        end
    endtask

    task automatic check1(input string name, input logic got, input logic exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%b exp=%b @%0t", name, got, exp, $time);
        end
    endtask

    // Reference result straight from RISC-V M-extension arithmetic.
    function automatic logic [31:0] ref_fn(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
        logic signed [63:0] sa, sb, sub, sp;
        logic [63:0]        ua, ub, up;
        int                 ia, ib;
        sa  = {{32{a[31]}}, a};
        sb  = {{32{b[31]}}, b};
        sub = {32'b0, b};
        ua  = {32'b0, a};
        ub  = {32'b0, b};
        ia  = a;
        ib  = b;
        case (op)
            3'd0: begin up = ua * ub; return up[31:0]; end
            3'd1: begin sp = sa * sb; return sp[63:32]; end
            3'd2: begin sp = sa * sub; return sp[63:32]; end
            3'd3: begin up = ua * ub; return up[63:32]; end
            3'd4: begin
                if (b == 0) return 32'hFFFFFFFF;
                if (a == 32'h80000000 && b == 32'hFFFFFFFF) return a;
                return ia / ib;
            end
            3'd5: return (b == 0) ? 32'hFFFFFFFF : a / b;
            3'd6: begin
                if (b == 0) return a;
                if (a == 32'h80000000 && b == 32'hFFFFFFFF) return 32'd0;
                return ia % ib;
            end
            default: return (b == 0) ? a : a % b;
        endcase
    endfunction

    // Cycles the op holds the pipeline, counting the accept cycle.
    function automatic int lat(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
        if (op[2]) begin
            if (b == 0) return 1;
            if ((op == 3'd4 || op == 3'd6) && a == 32'h80000000 && b == 32'hFFFFFFFF) return 1;
            return W + 1;
        end
        return MUL_STALL;
    endfunction

    // Model: m_left counts down to the strobe cycle (m_left==1); 0 means idle.
    int          m_left = 0;
    logic [31:0] m_res = '0;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_left <= 0;
        end else if (flush) begin
            m_left <= 0;
        end else if (m_left == 0) begin
            if (op_valid) begin
                m_left <= lat(op_sel, src_a, src_b);
                m_res  <= ref_fn(op_sel, src_a, src_b);
            end
        end else begin
            m_left <= m_left - 1;
        end
    end

    logic c_busy, c_valid, c_stall;
    always @(negedge clk) begin
        c_busy  = rst_n && (m_left != 0);
        c_valid = c_busy && (m_left == 1) && !flush;
        c_stall = op_valid && !flush && !(c_busy && m_left == 1);
        check1("cyc_busy", busy, c_busy);
        check1("cyc_valid", res_valid, c_valid);
        check1("cyc_stall", stallreq, c_stall);
        if (c_valid) check("cyc_result", result, m_res);
        else if (!rst_n) check("cyc_result_rst", result, 32'd0);
    end

    task automatic run_op(input string name, input logic [2:0] op, input logic [31:0] a,
                          input logic [31:0] b, input logic [31:0] exp_res, input int exp_stall);
        int          stalls;
        logic        got_v;
        logic [31:0] got;
        stalls   = 0;
        got_v    = 1'b0;
        got      = '0;
        op_valid = 1'b1;
        op_sel   = op;
        src_a    = a;
        src_b    = b;
        for (int i = 0; i < 100 && !got_v; i++) begin
            @(negedge clk);
            if (stallreq) stalls++;
            if (res_valid) begin
                got   = result;
                got_v = 1'b1;
            end
            @(posedge clk);
            #1;
        end
        op_valid = 1'b0;
        check1({name, "_strobe"}, got_v, 1'b1);
        if (got_v) begin
            check({name, "_result"}, got, exp_res);
            check({name, "_stall"}, stalls, exp_stall);
        end
        $display("op %s a=%h b=%h result=%h stall=%0d", name, a, b, got, stalls);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        #3;
        check1("rst_busy", busy, 1'b0);
        check1("rst_valid", res_valid, 1'b0);
        check1("rst_stall", stallreq, 1'b0);
        check("rst_result", result, 32'd0);
        @(posedge clk); @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;

        run_op("divu_100_7",   3'd5, 32'd100, 32'd7, 32'd14, 33);
        run_op("remu_100_7",   3'd7, 32'd100, 32'd7, 32'd2, 33);
        run_op("div_m7_2",     3'd4, 32'hFFFFFFF9, 32'd2, 32'hFFFFFFFD, 33);
        run_op("rem_m7_2",     3'd6, 32'hFFFFFFF9, 32'd2, 32'hFFFFFFFF, 33);
        run_op("div_7_m2",     3'd4, 32'd7, 32'hFFFFFFFE, 32'hFFFFFFFD, 33);
        run_op("rem_7_m2",     3'd6, 32'd7, 32'hFFFFFFFE, 32'd1, 33);
        run_op("div_ovf",      3'd4, 32'h80000000, 32'hFFFFFFFF, 32'h80000000, 1);
        run_op("rem_ovf",      3'd6, 32'h80000000, 32'hFFFFFFFF, 32'd0, 1);
        run_op("divu_5_0",     3'd5, 32'd5, 32'd0, 32'hFFFFFFFF, 1);
        run_op("remu_5_0",     3'd7, 32'd5, 32'd0, 32'd5, 1);
        run_op("div_m5_0",     3'd4, 32'hFFFFFFFB, 32'd0, 32'hFFFFFFFF, 1);
        run_op("rem_m5_0",     3'd6, 32'hFFFFFFFB, 32'd0, 32'hFFFFFFFB, 1);
        run_op("mulh_ones",    3'd1, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'd0, MUL_STALL);
        run_op("mulhu_ones",   3'd3, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, MUL_STALL);
        run_op("mulhsu_ones",  3'd2, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF, MUL_STALL);
        run_op("mul_ones",     3'd0, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'd1, MUL_STALL);
        run_op("mulh_m3_5",    3'd1, 32'hFFFFFFFD, 32'd5, 32'hFFFFFFFF, MUL_STALL);
        run_op("mulhu_big_4",  3'd3, 32'h80000000, 32'd4, 32'd2, MUL_STALL);

        // Flush in the 10th CALC cycle.
        op_valid = 1'b1; op_sel = 3'd5; src_a = 32'd1000; src_b = 32'd3;
        repeat (10) begin @(posedge clk); #1; end
        flush = 1'b1;
        @(negedge clk);
        check1("flush_stall", stallreq, 1'b0);
        check1("flush_valid", res_valid, 1'b0);
        @(posedge clk); #1;
        flush = 1'b0; op_valid = 1'b0;
        @(negedge clk);
        check1("flush_idle", busy, 1'b0);
        repeat (40) @(posedge clk);
        #1;
        $display("flush sequence complete busy=%b", busy);
        run_op("divu_9_3", 3'd5, 32'd9, 32'd3, 32'd3, 33);

        // Reset in the 5th CALC cycle.
        op_valid = 1'b1; op_sel = 3'd5; src_a = 32'd100; src_b = 32'd7;
        repeat (5) begin @(posedge clk); #1; end
        #1;
        rst_n = 1'b0; op_valid = 1'b0;
        #1;
        check1("midrst_busy", busy, 1'b0);
        check1("midrst_valid", res_valid, 1'b0);
        check("midrst_result", result, 32'd0);
        @(posedge clk); @(posedge clk); #1;
        rst_n = 1'b1;
        $display("reset sequence complete busy=%b", busy);
        run_op("mul_6_7", 3'd0, 32'd6, 32'd7, 32'd42, MUL_STALL);

        @(posedge clk); #1;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
